// File: rtl/sd_cmd_phy_control.sv
// SD command-line PHY controller: load/serialise/receive/report of one command with retry.
// Optional DAT0 busy wait after short+busy responses is enabled by defining BUSY_WAIT_EN.
module sd_cmd_phy_control #(
    parameter int SHORT_W        = 38,
    parameter int LONG_W         = 136,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRIES    = 2,
    parameter int GAP_CYCLES     = 8,
    parameter int BUSY_TIMEOUT   = 1024,
    localparam int RETRY_W       = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               iClock_SD,
    input  logic               iReset_n,
    input  logic               iStrobe_in,
    input  logic [1:0]         iResp_type,
    input  logic               iTransmission_complete,
    input  logic               iReception_complete,
    input  logic               iCrc_error,
    input  logic [LONG_W-1:0]  iPad_response,
    input  logic               iAck_in,
    input  logic               iIdle_in,
    input  logic               iDat0,
    output logic               oReset_wrapper,
    output logic               oEnable_PTS_wrapper,
    output logic               oEnable_STP_wrapper,
    output logic               oPad_enable,
    output logic               oLoad_send,
    output logic               oStrobe_out,
    output logic [LONG_W-1:0]  oResponse,
    output logic               oResp_long,
    output logic               oCommand_timeout,
    output logic               oCrc_error,
    output logic [RETRY_W-1:0] oRetry_count,
    output logic               oBusy,
    output logic               oAck_out
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_LOAD      = 4'd1;
    localparam logic [3:0] ST_SEND      = 4'd2;
    localparam logic [3:0] ST_WAIT_RESP = 4'd3;
    localparam logic [3:0] ST_RETRY_GAP = 4'd4;
    localparam logic [3:0] ST_SEND_RESP = 4'd6;
    localparam logic [3:0] ST_WAIT_ACK  = 4'd7;
    localparam logic [3:0] ST_SEND_ACK  = 4'd8;

    localparam logic [1:0] RT_NONE = 2'b00;
    localparam logic [1:0] RT_LONG = 2'b10;

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [LONG_W-1:0] SHORT_MASK = {{(LONG_W-SHORT_W){1'b0}}, {SHORT_W{1'b1}}};

    logic [3:0]         state_q,     state_d;
    logic [1:0]         type_q,      type_d;
    logic [TO_W-1:0]    to_cnt_q,    to_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q,   gap_cnt_d;
    logic [RETRY_W-1:0] retry_q,     retry_d;
    logic [LONG_W-1:0]  resp_q,      resp_d;
    logic               long_q,      long_d;
    logic               to_flag_q,   to_flag_d;
    logic               crc_flag_q,  crc_flag_d;

`ifdef BUSY_WAIT_EN
    localparam logic [3:0] ST_BUSY = 4'd5;
    localparam logic [1:0] RT_BUSY = 2'b11;
    localparam int         BUSY_W  = $clog2(BUSY_TIMEOUT);

    logic [BUSY_W-1:0]  busy_cnt_q,  busy_cnt_d;
`else
    // Busy detect is compiled out; DAT0 and its timeout have no effect.
    logic unused_busy_cfg;
    assign unused_busy_cfg = iDat0 ^ (BUSY_TIMEOUT > 0);
`endif

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        retry_d    = retry_q;
        resp_d     = resp_q;
        long_d     = long_q;
        to_flag_d  = to_flag_q;
        crc_flag_d = crc_flag_q;
`ifdef BUSY_WAIT_EN
        busy_cnt_d = busy_cnt_q;
`endif
        if (iIdle_in) begin
            state_d    = ST_IDLE;
            to_cnt_d   = '0;
            gap_cnt_d  = '0;
            retry_d    = '0;
            resp_d     = '0;
            long_d     = 1'b0;
            to_flag_d  = 1'b0;
            crc_flag_d = 1'b0;
`ifdef BUSY_WAIT_EN
            busy_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iStrobe_in) begin
                        type_d  = iResp_type;
                        retry_d = '0;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: state_d = ST_SEND;
                ST_SEND: begin
                    if (iTransmission_complete) begin
                        if (type_q == RT_NONE) begin
                            resp_d  = '0;
                            long_d  = 1'b0;
                            state_d = ST_SEND_RESP;
                        end else begin
                            to_cnt_d = '0;
                            state_d  = ST_WAIT_RESP;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    // A good reception on the last counted cycle beats the timeout.
                    if (iReception_complete && !iCrc_error) begin
                        resp_d  = (type_q == RT_LONG) ? iPad_response : (iPad_response & SHORT_MASK);
                        long_d  = (type_q == RT_LONG);
                        state_d = ST_SEND_RESP;
`ifdef BUSY_WAIT_EN
                        if (type_q == RT_BUSY) begin
                            busy_cnt_d = '0;
                            state_d    = ST_BUSY;
                        end
`endif
                    end else if (iReception_complete || (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
                        if (retry_q < RETRY_W'(MAX_RETRIES)) begin
                            retry_d   = retry_q + 1'b1;
                            gap_cnt_d = '0;
                            state_d   = ST_RETRY_GAP;
                        end else begin
                            crc_flag_d = iReception_complete;
                            to_flag_d  = !iReception_complete;
                            resp_d     = '0;
                            long_d     = 1'b0;
                            state_d    = ST_SEND_RESP;
                        end
                    end
                end
                ST_RETRY_GAP: begin
                    if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_d = ST_LOAD;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
`ifdef BUSY_WAIT_EN
                ST_BUSY: begin
                    // Busy timeout keeps the captured response and is never retried.
                    if (iDat0) begin
                        state_d = ST_SEND_RESP;
                    end else if (busy_cnt_q == BUSY_W'(BUSY_TIMEOUT - 1)) begin
                        to_flag_d = 1'b1;
                        state_d   = ST_SEND_RESP;
                    end else begin
                        busy_cnt_d = busy_cnt_q + 1'b1;
                    end
                end
`endif
                ST_SEND_RESP: state_d = ST_WAIT_ACK;
                ST_WAIT_ACK: begin
                    if (iAck_in) begin
                        state_d = ST_SEND_ACK;
                    end
                end
                ST_SEND_ACK: begin
                    resp_d     = '0;
                    long_d     = 1'b0;
                    to_flag_d  = 1'b0;
                    crc_flag_d = 1'b0;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClock_SD or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q    <= ST_IDLE;
            type_q     <= '0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            retry_q    <= '0;
            resp_q     <= '0;
            long_q     <= 1'b0;
            to_flag_q  <= 1'b0;
            crc_flag_q <= 1'b0;
`ifdef BUSY_WAIT_EN
            busy_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            retry_q    <= retry_d;
            resp_q     <= resp_d;
            long_q     <= long_d;
            to_flag_q  <= to_flag_d;
            crc_flag_q <= crc_flag_d;
`ifdef BUSY_WAIT_EN
            busy_cnt_q <= busy_cnt_d;
`endif
        end
    end

    assign oReset_wrapper      = (state_q == ST_IDLE) || (state_q == ST_RETRY_GAP);
    assign oEnable_PTS_wrapper = (state_q == ST_LOAD) || (state_q == ST_SEND);
    assign oPad_enable         = (state_q == ST_LOAD) || (state_q == ST_SEND);
    assign oLoad_send          = (state_q == ST_SEND);
    assign oEnable_STP_wrapper = (state_q == ST_WAIT_RESP);
    assign oStrobe_out         = (state_q == ST_SEND_RESP);
    assign oAck_out            = (state_q == ST_SEND_ACK);
`ifdef BUSY_WAIT_EN
    assign oBusy               = (state_q == ST_BUSY);
`else
    assign oBusy               = 1'b0;
`endif

    assign oResponse        = resp_q;
    assign oResp_long       = long_q;
    assign oCommand_timeout = to_flag_q;
    assign oCrc_error       = crc_flag_q;
    assign oRetry_count     = retry_q;

endmodule

// File: tb/tb_sd_cmd_phy_control.sv
// Bench for sd_cmd_phy_control: directed table, randomized commands against a
// transaction-level reference model, plus reset/abort/busy sequences.
module tb_sd_cmd_phy_control;

    localparam int SW  = 38;
    localparam int LW  = 136;
    localparam int TO  = 64;
    localparam int MR  = 2;
    localparam int GAP = 8;
    localparam int BT  = 1024;
    localparam int TX  = 5;

    localparam logic [LW-1:0] SMASK = {{(LW-SW){1'b0}}, {SW{1'b1}}};

    logic          iClock_SD = 1'b0;
    logic          iReset_n = 1'b1;
    logic          iStrobe_in = 1'b0;
    logic [1:0]    iResp_type = 2'b00;
    logic          iTransmission_complete = 1'b0;
    logic          iReception_complete = 1'b0;
    logic          iCrc_error = 1'b0;
    logic [LW-1:0] iPad_response = '0;
    logic          iAck_in = 1'b0;
    logic          iIdle_in = 1'b0;
    logic          iDat0 = 1'b0;
    logic          oReset_wrapper, oEnable_PTS_wrapper, oEnable_STP_wrapper, oPad_enable;
    logic          oLoad_send, oStrobe_out, oResp_long, oCommand_timeout, oCrc_error;
    logic          oBusy, oAck_out;
    logic [LW-1:0] oResponse;
    logic [1:0]    oRetry_count;

    int checks = 0;
    int errors = 0;

    sd_cmd_phy_control dut (
        .iClock_SD(iClock_SD), .iReset_n(iReset_n), .iStrobe_in(iStrobe_in),
        .iResp_type(iResp_type), .iTransmission_complete(iTransmission_complete),
        .iReception_complete(iReception_complete), .iCrc_error(iCrc_error),
        .iPad_response(iPad_response), .iAck_in(iAck_in), .iIdle_in(iIdle_in), .iDat0(iDat0),
        .oReset_wrapper(oReset_wrapper), .oEnable_PTS_wrapper(oEnable_PTS_wrapper),
        .oEnable_STP_wrapper(oEnable_STP_wrapper), .oPad_enable(oPad_enable),
        .oLoad_send(oLoad_send), .oStrobe_out(oStrobe_out), .oResponse(oResponse),
        .oResp_long(oResp_long), .oCommand_timeout(oCommand_timeout), .oCrc_error(oCrc_error),
        .oRetry_count(oRetry_count), .oBusy(oBusy), .oAck_out(oAck_out)
    );

    always #5 iClock_SD = ~iClock_SD;

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    typedef struct packed {
        logic [1:0]           typ;
        logic [2:0][7:0]      dly;   // WAIT_RESP cycle index of reception per attempt, >=TO means none
        logic [2:0]           crc;
        logic [2:0][LW-1:0]   dat;
        logic [LW-1:0]        exp_resp;
        logic                 exp_long;
        logic                 exp_to;
        logic                 exp_crc;
        logic [1:0]           exp_retry;
    } vec_t;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd136();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[LW-1:0];
    endfunction

    function automatic vec_t mk(input logic [1:0] typ, input int d0, input int d1, input int d2,
                                input logic [2:0] crc, input logic [LW-1:0] x0, input logic [LW-1:0] x1,
                                input logic [LW-1:0] x2, input logic [LW-1:0] er, input logic el,
                                input logic eto, input logic ecrc, input logic [1:0] ert);
        vec_t v;
        v.typ = typ;
        v.dly[0] = 8'(d0); v.dly[1] = 8'(d1); v.dly[2] = 8'(d2);
        v.crc = crc;
        v.dat[0] = x0; v.dat[1] = x1; v.dat[2] = x2;
        v.exp_resp = er; v.exp_long = el; v.exp_to = eto; v.exp_crc = ecrc; v.exp_retry = ert;
        return v;
    endfunction

    // Reference: walk the attempts, the first clean reception in time wins; otherwise the
    // last attempt's cause is reported. Also yields attempt count and total WAIT_RESP cycles.
    function automatic void model(inout vec_t v, output int n_att, output int waits);
        v.exp_resp = '0; v.exp_long = 1'b0; v.exp_to = 1'b0; v.exp_crc = 1'b0; v.exp_retry = 2'd0;
        n_att = 1;
        waits = 0;
        if (v.typ == 2'b00) return;
        for (int a = 0; a <= MR; a++) begin
            n_att = a + 1;
            v.exp_retry = 2'(a);
            if (int'(v.dly[a]) < TO) begin
                waits += int'(v.dly[a]) + 1;
                if (!v.crc[a]) begin
                    v.exp_long = (v.typ == 2'b10);
                    v.exp_resp = v.exp_long ? v.dat[a] : (v.dat[a] & SMASK);
                    return;
                end
                if (a == MR) v.exp_crc = 1'b1;
            end else begin
                waits += TO;
                if (a == MR) v.exp_to = 1'b1;
            end
        end
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        v = '0;
        v.typ = 2'($urandom_range(0, 3));
        for (int a = 0; a < 3; a++) begin
            int r;
            r = $urandom_range(0, 9);
            v.dly[a] = (r < 2) ? 8'hFF : (r < 3) ? 8'($urandom_range(62, 65)) : 8'($urandom_range(0, 20));
            v.crc[a] = ($urandom_range(0, 2) == 0);
            v.dat[a] = rnd136();
        end
        return v;
    endfunction

    // Acts as host + PTS/STP wrappers for one command, then checks the reported result.
    task automatic run_cmd(input vec_t v, input int busy_len, input bit abort_at_ack, input string nm);
        vec_t e;
        int n_att, waits, exp_busy;
        int cyc, loads, ls, ls_run, wr, wr_run, gaps, rx_cyc, busy_cnt, rise_cyc, att, ai;
        bit ok_resp, busy_cmd, started, got;
        e = v;
        model(e, n_att, waits);
        ok_resp = (v.typ != 2'b00) && !e.exp_to && !e.exp_crc;
`ifdef BUSY_WAIT_EN
        busy_cmd = ok_resp && (v.typ == 2'b11);
`else
        busy_cmd = 1'b0;
`endif
        exp_busy = !busy_cmd ? 0 : (busy_len < BT) ? busy_len + 1 : BT;
        if (busy_cmd && busy_len >= BT) e.exp_to = 1'b1;
        cyc = 0; loads = 0; ls = 0; ls_run = 0; wr = 0; wr_run = 0; gaps = 0;
        rx_cyc = -100; busy_cnt = 0; rise_cyc = -100; att = -1; started = 0; got = 0;

        @(negedge iClock_SD);
        iStrobe_in = 1'b1;
        iResp_type = v.typ;
        @(negedge iClock_SD);
        iStrobe_in = 1'b0;
        iResp_type = 2'($urandom_range(0, 3));
        while (!got && cyc < 3000) begin
            iTransmission_complete = 1'b0;
            iReception_complete = 1'b0;
            iCrc_error = 1'($urandom_range(0, 1));
            iPad_response = rnd136();
            iStrobe_in = 1'b0;
            if (oStrobe_out) begin
                got = 1;
            end else begin
                iStrobe_in = !oReset_wrapper && ($urandom_range(0, 3) == 0);
                if (oEnable_PTS_wrapper && !oLoad_send) begin
                    loads++; att++; started = 1;
                end
                ai = (att < 0) ? 0 : (att > 2) ? 2 : att;
                if (oLoad_send) begin
                    ls++; ls_run++;
                    if (ls_run == TX) begin
                        iTransmission_complete = 1'b1;
                        ls_run = 0;
                    end
                end
                if (oEnable_STP_wrapper) begin
                    wr++;
                    if (wr_run == int'(v.dly[ai])) begin
                        iReception_complete = 1'b1;
                        iCrc_error = v.crc[ai];
                        iPad_response = v.dat[ai];
                        rx_cyc = cyc;
                    end
                    wr_run++;
                end else begin
                    wr_run = 0;
                end
                if (started && oReset_wrapper) gaps++;
                if (oBusy) busy_cnt++;
`ifdef BUSY_WAIT_EN
                iDat0 = oBusy ? (busy_cnt > busy_len) : 1'($urandom_range(0, 1));
                if (oBusy && busy_cnt == busy_len + 1) rise_cyc = cyc;
`else
                iDat0 = 1'($urandom_range(0, 1));
`endif
                cyc++;
                @(negedge iClock_SD);
            end
        end
        if (!got) begin
            errors++; checks++;
            $display("FAIL %s no strobe within %0d cycles", nm, cyc);
            return;
        end
        chk({nm, " resp"}, oResponse, e.exp_resp);
        chk({nm, " long"}, oResp_long, e.exp_long);
        chk({nm, " timeout"}, oCommand_timeout, e.exp_to);
        chk({nm, " crc"}, oCrc_error, e.exp_crc);
        chk({nm, " retry"}, oRetry_count, e.exp_retry);
        chk({nm, " loads"}, LW'(loads), LW'(n_att));
        chk({nm, " send cycles"}, LW'(ls), LW'(n_att * TX));
        chk({nm, " gap cycles"}, LW'(gaps), LW'((n_att - 1) * GAP));
        chk({nm, " wait cycles"}, LW'(wr), LW'(waits));
        chk({nm, " busy cycles"}, LW'(busy_cnt), LW'(exp_busy));
        if (busy_cmd && busy_len < BT)
            chk({nm, " busy latency"}, LW'(cyc - rise_cyc), LW'(1));
        else if (ok_resp && !busy_cmd)
            chk({nm, " strobe latency"}, LW'(cyc - rx_cyc), LW'(1));

        repeat ($urandom_range(1, 4)) begin
            @(negedge iClock_SD);
            chk({nm, " strobe one cycle"}, oStrobe_out, 1'b0);
            chk({nm, " resp held"}, oResponse, e.exp_resp);
        end
        if (abort_at_ack) begin
            iIdle_in = 1'b1;
            @(negedge iClock_SD);
            iIdle_in = 1'b0;
            chk({nm, " abort ack"}, oAck_out, 1'b0);
            chk({nm, " abort retry"}, oRetry_count, 2'd0);
            chk({nm, " abort flags"}, {oCommand_timeout, oCrc_error, oResp_long}, 3'b000);
            chk({nm, " abort resp"}, oResponse, '0);
            chk({nm, " abort idle"}, oReset_wrapper, 1'b1);
        end else begin
            iAck_in = 1'b1;
            @(negedge iClock_SD);
            iAck_in = 1'b0;
            chk({nm, " ack pulse"}, oAck_out, 1'b1);
            @(negedge iClock_SD);
            chk({nm, " ack one cycle"}, oAck_out, 1'b0);
            chk({nm, " idle"}, oReset_wrapper, 1'b1);
            chk({nm, " cleared"}, {oCommand_timeout, oCrc_error, oResp_long}, 3'b000);
            chk({nm, " resp cleared"}, oResponse, '0);
        end
    endtask

    // Abort with iIdle_in while in WAIT_RESP or BUSY, racing a completion event.
    task automatic abort_test(input bit in_busy, input string nm);
        int n, lr;
        bit hit;
        n = 0; lr = 0; hit = 0;
        @(negedge iClock_SD);
        iStrobe_in = 1'b1;
        iResp_type = in_busy ? 2'b11 : 2'b01;
        @(negedge iClock_SD);
        iStrobe_in = 1'b0;
        while (!hit && n < 100) begin
            iTransmission_complete = 1'b0;
            iReception_complete = 1'b0;
            iCrc_error = 1'b0;
            iDat0 = 1'b0;
            if (oLoad_send) begin
                lr++;
                if (lr == TX) iTransmission_complete = 1'b1;
            end
            if (oEnable_STP_wrapper) begin
                if (in_busy) iReception_complete = 1'b1;
                else hit = 1;
            end
            if (oBusy) hit = 1;
            if (!hit) begin
                n++;
                @(negedge iClock_SD);
            end
        end
        if (!hit) begin
            errors++; checks++;
            $display("FAIL %s target state not reached", nm);
            return;
        end
        iIdle_in = 1'b1;
        iReception_complete = 1'b1;
        iPad_response = rnd136();
        iDat0 = 1'b1;
        @(negedge iClock_SD);
        iIdle_in = 1'b0;
        iReception_complete = 1'b0;
        iDat0 = 1'b0;
        chk({nm, " idle"}, oReset_wrapper, 1'b1);
        chk({nm, " stp off"}, oEnable_STP_wrapper, 1'b0);
        chk({nm, " busy off"}, oBusy, 1'b0);
        repeat (4) begin
            chk({nm, " no strobe"}, oStrobe_out, 1'b0);
            chk({nm, " resp zero"}, oResponse, '0);
            @(negedge iClock_SD);
        end
    endtask

    vec_t tbl [8];
    logic [LW-1:0] d1, d2, d3, ones;

    initial begin
        d1   = {{(LW-SW){1'b1}}, 38'h2A12345678};
        d2   = 136'h89ABCDEF0123456789ABCDEF01234567A5;
        d3   = 136'h0F1E2D3C4B5A69788796A5B4C3D2E1F0C3;
        ones = '1;
        tbl[0] = mk(2'b01, 10, 255, 255, 3'b000, d1, d2, d3, {{(LW-SW){1'b0}}, 38'h2A12345678}, 0, 0, 0, 2'd0);
        tbl[1] = mk(2'b10, 3, 255, 255, 3'b000, d2, d1, d3, d2, 1, 0, 0, 2'd0);
        tbl[2] = mk(2'b01, 255, 255, 255, 3'b000, d1, d2, d3, '0, 0, 1, 0, 2'd2);
        tbl[3] = mk(2'b01, 7, 63, 255, 3'b001, d1, d3, d2, {{(LW-SW){1'b0}}, d3[SW-1:0]}, 0, 0, 0, 2'd1);
        tbl[4] = mk(2'b00, 0, 0, 0, 3'b000, d1, d2, d3, '0, 0, 0, 0, 2'd0);
        tbl[5] = mk(2'b10, 2, 5, 0, 3'b111, d2, d2, d2, '0, 0, 0, 1, 2'd2);
        tbl[6] = mk(2'b11, 0, 255, 255, 3'b000, ones, d1, d2, SMASK, 0, 0, 0, 2'd0);
        tbl[7] = mk(2'b01, 64, 3, 255, 3'b010, d1, d2, d3, '0, 0, 1, 0, 2'd2);

        #1 iReset_n = 1'b0;
        @(negedge iClock_SD);
        @(negedge iClock_SD);
        chk("reset wrapper", oReset_wrapper, 1'b1);
        chk("reset ctrl", {oEnable_PTS_wrapper, oEnable_STP_wrapper, oPad_enable, oLoad_send,
                           oStrobe_out, oBusy, oAck_out}, 7'd0);
        chk("reset result", {oResp_long, oCommand_timeout, oCrc_error, oRetry_count}, 5'd0);
        chk("reset resp", oResponse, '0);
        iReset_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_cmd(tbl[i], 20, 1'b0, $sformatf("tbl%0d", i));

        // Reset asserted while the serialiser is running.
        @(negedge iClock_SD);
        iStrobe_in = 1'b1;
        iResp_type = 2'b01;
        @(negedge iClock_SD);
        iStrobe_in = 1'b0;
        @(negedge iClock_SD);
        chk("midsend in send", oLoad_send, 1'b1);
        iReset_n = 1'b0;
        #1;
        chk("midsend wrapper", oReset_wrapper, 1'b1);
        chk("midsend ctrl", {oEnable_PTS_wrapper, oPad_enable, oLoad_send, oStrobe_out, oAck_out}, 5'd0);
        @(negedge iClock_SD);
        iReset_n = 1'b1;
        repeat (3) begin
            @(negedge iClock_SD);
            chk("midsend stays idle", {oReset_wrapper, oEnable_PTS_wrapper}, 2'b10);
        end

        abort_test(1'b0, "abort wait");
        run_cmd(tbl[2], 20, 1'b1, "abort at ack");
`ifdef BUSY_WAIT_EN
        abort_test(1'b1, "abort busy");
        run_cmd(tbl[6], BT + 5, 1'b0, "busy timeout");
`endif

        for (int i = 0; i < 12; i++)
            run_cmd(rnd_vec(), $urandom_range(0, 30), ($urandom_range(0, 5) == 0), $sformatf("rnd%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_cmd_phy_control.md
Name: sd_cmd_phy_control

Overview:
- Parametrised successor of the SD command-line physical-block controller.
- Sequences load/serialise/receive/report of one command between the host-side command block and the PTS/STP wrappers in the SD clock domain.
- Adds the following over the previous generation:
  - per-command response type (none, short, long, short+busy);
  - parametrised response width and timeout;
  - automatic retry on timeout or CRC error;
  - error reporting through the normal strobe/ack handshake.

Parameters:
SHORT_W, 38, short-response payload width (bits)
LONG_W, 136, long-response payload width; width of iPad_response/oResponse
TIMEOUT_CYCLES, 64, max cycles in WAIT_RESP before timeout (>=2)
MAX_RETRIES, 2, retries after first attempt (0 = no retry)
GAP_CYCLES, 8, idle cycles between retry attempts (>=1)
BUSY_TIMEOUT, 1024, max cycles waiting for DAT0 release (BUSY_WAIT_EN only)

Ports:
iClock_SD  in  1  SD clock; all state on rising edge
iReset_n  in  1  asynchronous active-low reset
iStrobe_in  in  1  host command request, sampled only in IDLE
iResp_type  in  2  00 none, 01 short, 10 long, 11 short+busy; latched with iStrobe_in
iTransmission_complete  in  1  PTS wrapper finished command
iReception_complete  in  1  STP wrapper captured full response
iCrc_error  in  1  STP CRC7 mismatch, valid with iReception_complete
iPad_response  in  LONG_W  captured response, LSB-aligned
iAck_in  in  1  host acknowledges reported result
iIdle_in  in  1  synchronous abort
iDat0  in  1  DAT0 line level (busy detect)
oReset_wrapper  out  1  active-high clear of PTS/STP wrappers
oEnable_PTS_wrapper  out  1  enable serialiser
oEnable_STP_wrapper  out  1  enable deserialiser
oPad_enable  out  1  CMD pad output enable
oLoad_send  out  1  serialiser shift enable
oStrobe_out  out  1  one-cycle result-valid pulse
oResponse  out  LONG_W  reported response
oResp_long  out  1  oResponse holds long response
oCommand_timeout  out  1  no response / busy timeout after all retries
oCrc_error  out  1  CRC error after all retries
oRetry_count  out  $clog2(MAX_RETRIES+1)  retries used for current command
oBusy  out  1  waiting for DAT0 release
oAck_out  out  1  one-cycle completion pulse to host

Behaviour:
- Reset (iReset_n low, async):
  - state IDLE; all counters and latched registers zero.
  - oReset_wrapper=1; every other output 0.
- Priority per edge: reset > iIdle_in > state logic.
  - iIdle_in=1 forces IDLE next cycle from any state.
  - Clears retry count, flags and oResponse; counts as abort, no oStrobe_out.
- States: IDLE, LOAD, SEND, WAIT_RESP, RETRY_GAP, BUSY, SEND_RESP, WAIT_ACK, SEND_ACK.
- Control outputs are a combinational decode of the state register. oResponse, oResp_long, the flags and oRetry_count are registers.
- IDLE:
  - oReset_wrapper=1.
  - iStrobe_in=1: latch iResp_type, clear retry count, go LOAD. Otherwise stay.
  - iStrobe_in is ignored in all other states.
- LOAD (1 cycle): oEnable_PTS_wrapper=1, oPad_enable=1 -> SEND.
- SEND:
  - oEnable_PTS_wrapper=1, oPad_enable=1, oLoad_send=1.
  - On iTransmission_complete: type 00 -> SEND_RESP with oResponse=0; else -> WAIT_RESP with timeout counter=0.
- WAIT_RESP:
  - oEnable_STP_wrapper=1, oPad_enable=0; counter increments each cycle.
  - iReception_complete & !iCrc_error:
    - capture iPad_response; for short types, bits above SHORT_W-1 are zeroed.
    - oResp_long=(type==10).
    - -> BUSY if type 11 (see Optional Feature); else SEND_RESP.
  - iReception_complete & iCrc_error, or counter==TIMEOUT_CYCLES-1 with no reception: failure.
  - Reception on the final counter cycle wins over timeout.
- Failure handling:
  - If oRetry_count<MAX_RETRIES: increment it, go RETRY_GAP.
  - Else: set oCrc_error or oCommand_timeout (matching cause), oResponse=0, go SEND_RESP.
- RETRY_GAP: oReset_wrapper=1 for exactly GAP_CYCLES cycles -> LOAD. The command is re-sent from the unchanged PTS load.
- SEND_RESP (1 cycle): oStrobe_out=1 -> WAIT_ACK.
- WAIT_ACK: result registers held stable; iAck_in=1 -> SEND_ACK.
- SEND_ACK (1 cycle): oAck_out=1 -> IDLE. Flags, oResponse and oResp_long clear on entering IDLE.
- Latency, type 01, no errors: iReception_complete at cycle N -> oStrobe_out at N+1.

Optional Feature:
- Macro BUSY_WAIT_EN.
- Defined:
  - Type 11 after a good response enters BUSY; oBusy=1 and a busy counter runs.
  - iDat0=1 -> SEND_RESP.
  - Counter reaching BUSY_TIMEOUT-1 -> SEND_RESP with oCommand_timeout=1 and the response kept. No retry for busy timeout.
- Undefined:
  - BUSY state and busy counter are absent; type 11 behaves exactly as 01.
  - iDat0 is ignored; oBusy is tied 0.

Test Plan:
1. Reset mid-SEND (iReset_n low 1 cycle) -> immediate oReset_wrapper=1, all other outputs 0, state IDLE.
2. Type 01, reception 10 cycles after transmission complete, iPad_response=38'h2A_1234_5678 -> oStrobe_out next cycle, oResponse=38'h2A_1234_5678 (upper bits 0), oResp_long=0; iAck_in -> oAck_out 1 cycle.
3. Type 10, LONG_W=136 pattern -> full 136 bits reported, oResp_long=1.
4. Type 01, never respond, MAX_RETRIES=2 -> two RETRY_GAP periods of 8 cycles, three SEND phases, then oCommand_timeout=1, oRetry_count=2, oResponse=0.
5. Type 01, CRC error on first attempt, clean on second -> oCrc_error=0, oRetry_count=1, correct response; reception on cycle 63 with TIMEOUT_CYCLES=64 -> accepted, no timeout.
6. BUSY_WAIT_EN, type 11: iDat0 low 20 cycles -> oBusy=1 throughout, strobe 1 cycle after iDat0 rises. iIdle_in during BUSY -> IDLE, no strobe.
